// File: rtl/feadd.sv
// feadd: sequential modular adder over GF(2^255 - 19).
// Adds two canonical 255-bit operands one 51-bit limb per cycle, then
// conditionally subtracts p, also limb-serially, to give a canonical result.
module feadd (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic         done,
  output logic [254:0] out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SUB,
    DONE
  } state_t;

  state_t       state;
  logic [254:0] a_r;
  logic [254:0] b_r;
  logic [254:0] s_r;     // sum limbs; rotated through during SUB
  logic         s_top;   // bit 255 of the full sum
  logic [254:0] t_r;     // s - p, assembled limb by limb
  logic         carry;
  logic         borrow;
  logic [2:0]   k;

  logic [51:0]  add_w;
  logic [50:0]  p_limb;
  logic [51:0]  sub_w;
  logic         ge;

  // Limb datapath: low limb of each shift register feeds the adder/subtractor
  always_comb begin
    add_w  = {1'b0, a_r[50:0]} + {1'b0, b_r[50:0]} + {51'b0, carry};
    p_limb = (k == 3'd0) ? 51'h7FFFFFFFFFFED : '1;
    sub_w  = {1'b0, s_r[50:0]} - {1'b0, p_limb} - {51'b0, borrow};
    ge     = s_top | ~borrow;
  end

  // Control FSM with registered done/busy/out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      busy   <= 1'b0;
      out    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      s_top  <= 1'b0;
      t_r    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      k      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            carry  <= 1'b0;
            borrow <= 1'b0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ADD: begin
          a_r   <= a_r >> 51;
          b_r   <= b_r >> 51;
          s_r   <= {add_w[50:0], s_r[254:51]};
          carry <= add_w[51];
          if (k == 3'd4) begin
            s_top  <= add_w[51];
            borrow <= 1'b0;
            k      <= '0;
            state  <= SUB;
          end else begin
            k <= k + 3'd1;
          end
        end
        SUB: begin
          // Limbs 0..4 subtract while s_r rotates back to its original order;
          // the extra k=5 cycle performs the select so out updates with done.
          if (k == 3'd5) begin
            out   <= ge ? t_r : s_r;
            done  <= 1'b1;
            k     <= '0;
            state <= DONE;
          end else begin
            s_r    <= {s_r[50:0], s_r[254:51]};
            t_r    <= {sub_w[50:0], t_r[254:51]};
            borrow <= sub_w[51];
            k      <= k + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
